snoopy_vertical_fsm: RTL and testbench

//  Vertical (y-axis) motion controller for Snoopy; the y-direction partner of the horizontal x controller.

---
 rtl/snoopy_pkg.sv | 30 +++
 rtl/snoopy_frame_tick.sv | 33 +++
 rtl/snoopy_vertical_fsm.sv | 147 ++++++++++++++
 tb/tb_snoopy_vertical_fsm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/snoopy_pkg.sv
`default_nettype none
// ============================================================================
// Package  : snoopy_pkg
// Brief    : Shared Snoopy motion types, state encodings and screen constants.
// Revision : 1.0 - initial release
// ============================================================================
package snoopy_pkg;

    localparam int SCREEN_H = 480;
    localparam int POS_W    = 10;
    localparam int SPEED_W  = 8;

    typedef enum logic [1:0] {
        S_GROUND = 2'b00,
        S_RISE   = 2'b01,
        S_FALL   = 2'b10
    } snoopy_state_t;

    typedef logic        [POS_W-1:0]   pos_t;
    typedef logic signed [POS_W:0]     pos_ext_t;
    typedef logic signed [SPEED_W-1:0] speed_t;
    typedef logic signed [SPEED_W:0]   speed_ext_t;

    // One bit of headroom in the sum keeps the cap compare free of wraparound.
    function automatic speed_t speed_cap(input speed_ext_t sum, input speed_ext_t cap);
        return (sum > cap) ? speed_t'(cap) : speed_t'(sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoopy_frame_tick.sv
`default_nettype none
// ============================================================================
// Module   : snoopy_frame_tick
// Brief    : Free-running frame tick divider; tick is high on the last count.
// Revision : 1.0 - initial release
// ============================================================================
module snoopy_frame_tick #(
    parameter int TICK_DIV = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/snoopy_vertical_fsm.sv
`default_nettype none
// ============================================================================
// Module   : snoopy_vertical_fsm
// Brief    : Y-axis jump/gravity controller: rise, apex, fall, land per tick.
//            Optional macro SNOOPY_DOUBLE_JUMP_EN allows one mid-air jump.
// Revision : 1.0 - initial release
// ============================================================================
module snoopy_vertical_fsm
    import snoopy_pkg::*;
#(
    parameter int GROUND_Y   = 400,
    parameter int CEIL_Y     = 0,
    parameter int JUMP_SPEED = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12,
    parameter int TICK_DIV   = 833333
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_jump,
    output logic [POS_W-1:0] snoopy_y,
    output logic             airborne,
    output logic             land_pulse
);

    // Landing row is kept on-screen even if misconfigured.
    localparam int c_ground_int = (GROUND_Y < SCREEN_H) ? GROUND_Y : SCREEN_H - 1;

    localparam pos_t       c_ground_y   = pos_t'(c_ground_int);
    localparam pos_t       c_ceil_y     = pos_t'(CEIL_Y);
    localparam pos_ext_t   c_ground_ext = pos_ext_t'(c_ground_int);
    localparam pos_ext_t   c_ceil_ext   = pos_ext_t'(CEIL_Y);
    localparam speed_t     c_jump_spd   = speed_t'(-JUMP_SPEED);
    localparam speed_ext_t c_gravity    = speed_ext_t'(GRAVITY);
    localparam speed_ext_t c_max_fall   = speed_ext_t'(MAX_FALL);

    logic          w_tick;
    logic          w_jump_rise;
    pos_ext_t      w_y_nxt;
    speed_ext_t    w_spd_sum;
    speed_t        w_spd_nxt;

    logic          r_jump_q;
    logic          r_jump_pend;
    snoopy_state_t r_state;
    pos_t          r_y;
    speed_t        r_speed;
    logic          r_airborne;
    logic          r_land;
`ifdef SNOOPY_DOUBLE_JUMP_EN
    logic          r_dj_used;
`endif

    snoopy_frame_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_frame_tick (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_jump_rise = input_jump & ~r_jump_q;

    // Signed, one bit wider than the position so overshoot past either edge is visible.
    assign w_y_nxt   = pos_ext_t'({1'b0, r_y}) + pos_ext_t'(r_speed);
    assign w_spd_sum = speed_ext_t'(r_speed) + c_gravity;
    assign w_spd_nxt = speed_cap(w_spd_sum, c_max_fall);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_jump_q    <= input_jump;
            r_jump_pend <= 1'b0;
            r_state     <= S_GROUND;
            r_y         <= c_ground_y;
            r_speed     <= '0;
            r_airborne  <= 1'b0;
            r_land      <= 1'b0;
`ifdef SNOOPY_DOUBLE_JUMP_EN
            r_dj_used   <= 1'b0;
`endif
        end else begin
            r_jump_q <= input_jump;
            r_land   <= 1'b0;

            // A press landing on the tick clock survives to the following tick.
            if (w_jump_rise) begin
                r_jump_pend <= 1'b1;
            end else if (w_tick) begin
                r_jump_pend <= 1'b0;
            end

            if (w_tick) begin
                case (r_state)
                    S_GROUND: begin
                        if (r_jump_pend) begin
                            r_state    <= S_RISE;
                            r_speed    <= c_jump_spd;
                            r_airborne <= 1'b1;
                        end
                    end
                    S_RISE, S_FALL: begin
                        if (w_y_nxt >= c_ground_ext) begin
                            r_state    <= S_GROUND;
                            r_y        <= c_ground_y;
                            r_speed    <= '0;
                            r_airborne <= 1'b0;
                            r_land     <= 1'b1;
`ifdef SNOOPY_DOUBLE_JUMP_EN
                            r_dj_used  <= 1'b0;
`endif
                        end
`ifdef SNOOPY_DOUBLE_JUMP_EN
                        else if (r_jump_pend && !r_dj_used) begin
                            r_state   <= S_RISE;
                            r_speed   <= c_jump_spd;
                            r_dj_used <= 1'b1;
                        end
`endif
                        else if (w_y_nxt < c_ceil_ext) begin
                            r_state <= S_FALL;
                            r_y     <= c_ceil_y;
                            r_speed <= '0;
                        end else begin
                            r_y     <= w_y_nxt[POS_W-1:0];
                            r_speed <= w_spd_nxt;
                            if (r_state == S_RISE && !w_spd_nxt[SPEED_W-1]) begin
                                r_state <= S_FALL;
                            end
                        end
                    end
                    default: begin
                        r_state    <= S_GROUND;
                        r_y        <= c_ground_y;
                        r_speed    <= '0;
                        r_airborne <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign snoopy_y   = r_y;
    assign airborne   = r_airborne;
    assign land_pulse = r_land;

endmodule
`default_nettype wire

// File: tb/tb_snoopy_vertical_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoopy_vertical_fsm
// Brief    : Directed, table-driven bench for snoopy_vertical_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoopy_vertical_fsm;

    localparam int TB_DIV = 4;

    logic       clock;
    logic       reset;
    logic       input_jump;
    logic       jump2;
    logic [9:0] y1, y2;
    logic       air1, air2, land1, land2;

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cnt   = 0;

    typedef struct {
        bit jump;
        int y;
        bit air;
        bit land;
    } vec_t;

    vec_t vecs[$];

    snoopy_vertical_fsm #(
        .GROUND_Y(400), .CEIL_Y(0), .JUMP_SPEED(4), .GRAVITY(1), .MAX_FALL(4), .TICK_DIV(TB_DIV)
    ) dut (
        .clock(clock), .reset(reset), .input_jump(input_jump),
        .snoopy_y(y1), .airborne(air1), .land_pulse(land1)
    );

    snoopy_vertical_fsm #(
        .GROUND_Y(400), .CEIL_Y(395), .JUMP_SPEED(4), .GRAVITY(1), .MAX_FALL(4), .TICK_DIV(TB_DIV)
    ) dut_ceil (
        .clock(clock), .reset(reset), .input_jump(jump2),
        .snoopy_y(y2), .airborne(air2), .land_pulse(land2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference frame counter: tells the bench which edge is a motion tick.
    always @(posedge clock) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == TB_DIV - 1) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick_sample();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * TB_DIV && !seen; i++) begin
            @(posedge clock);
            if (tb_cnt == TB_DIV - 1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL tick_timeout: got no tick, expected one within %0d clocks", 2 * TB_DIV);
        end
        @(negedge clock);
    endtask

    function automatic void add(input bit j, input int y, input bit a, input bit l);
        vec_t v;
        v.jump = j; v.y = y; v.air = a; v.land = l;
        vecs.push_back(v);
    endfunction

    initial begin
        int ceil_y[7];
        reset      = 1'b1;
        input_jump = 1'b0;
        jump2      = 1'b0;

        // Full jump, then held button through landing.
        add(1, 400, 1, 0); add(0, 396, 1, 0); add(0, 393, 1, 0); add(0, 391, 1, 0);
        add(0, 390, 1, 0); add(0, 390, 1, 0); add(0, 391, 1, 0); add(0, 393, 1, 0);
        add(0, 396, 1, 0); add(0, 400, 0, 1); add(0, 400, 0, 0);
        add(1, 400, 1, 0); add(1, 396, 1, 0); add(1, 393, 1, 0); add(1, 391, 1, 0);
        add(1, 390, 1, 0); add(1, 390, 1, 0); add(1, 391, 1, 0); add(1, 393, 1, 0);
        add(1, 396, 1, 0); add(1, 400, 0, 1); add(1, 400, 0, 0); add(1, 400, 0, 0);
        add(0, 400, 0, 0);
        // Airborne presses at y=393 and again two ticks later.
        add(1, 400, 1, 0); add(0, 396, 1, 0); add(0, 393, 1, 0);
`ifdef SNOOPY_DOUBLE_JUMP_EN
        add(1, 393, 1, 0); add(0, 389, 1, 0); add(0, 386, 1, 0); add(1, 384, 1, 0);
        add(0, 383, 1, 0); add(0, 383, 1, 0); add(0, 384, 1, 0); add(0, 386, 1, 0);
        add(0, 389, 1, 0); add(0, 393, 1, 0); add(0, 397, 1, 0); add(0, 400, 0, 1);
`else
        add(1, 391, 1, 0); add(0, 390, 1, 0); add(1, 390, 1, 0); add(0, 391, 1, 0);
        add(0, 393, 1, 0); add(0, 396, 1, 0); add(0, 400, 0, 1);
`endif
        add(0, 400, 0, 0);

        // Reset state and first-tick phase.
        repeat (3) @(negedge clock);
        check("reset_y", y1, 400);
        check("reset_air", air1, 0);
        check("reset_land", land1, 0);
        reset      = 1'b0;
        input_jump = 1'b1;
        repeat (3) @(negedge clock);
        check("pre_tick_air", air1, 0);
        @(negedge clock);
        check("first_tick_air", air1, 1);
        check("first_tick_y", y1, 400);
        input_jump = 1'b0;
        tick_sample(); check("early_y1", y1, 396);
        tick_sample(); check("early_y2", y1, 393);
        tick_sample(); check("early_y3", y1, 391);

        // Reset while airborne snaps straight to ground.
        reset = 1'b1;
        @(negedge clock);
        check("midair_reset_y", y1, 400);
        check("midair_reset_air", air1, 0);
        check("midair_reset_land", land1, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        foreach (vecs[k]) begin
            input_jump = vecs[k].jump;
            tick_sample();
            check($sformatf("vec%0d_y", k), y1, vecs[k].y);
            check($sformatf("vec%0d_air", k), air1, vecs[k].air);
            check($sformatf("vec%0d_land", k), land1, vecs[k].land);
            if (vecs[k].land) begin
                @(negedge clock);
                check($sformatf("vec%0d_land_width", k), land1, 0);
            end
        end

        // Ceiling clamp on the CEIL_Y=395 instance.
        ceil_y = '{400, 396, 395, 395, 396, 398, 400};
        jump2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick_sample();
            jump2 = 1'b0;
            check($sformatf("ceil%0d_y", i), y2, ceil_y[i]);
            check($sformatf("ceil%0d_air", i), air2, (i < 6) ? 1 : 0);
            check($sformatf("ceil%0d_land", i), land2, (i == 6) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
